// File: rtl/bch_link_engine.sv
`default_nettype none
// ============================================================================
// bch_link_engine : bit-serial BCH encode -> error inject -> syndrome decode.
// Optional Meggitt single-error correction when BCH_CORRECT_EN is defined.
// Revision 1.0
// ============================================================================
module bch_link_engine #(
  parameter int MSG_W    = 8,
  parameter     GEN_POLY = 6'b100101
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [MSG_W-1:0]                      msg_i,
  input  logic [1:0]                            err_mode_i,
  input  logic [MSG_W+$bits(GEN_POLY)-2:0]      err_mask_i,
  input  logic [3:0]                            err_cnt_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [MSG_W+$bits(GEN_POLY)-2:0]      codeword_o,
  output logic [MSG_W+$bits(GEN_POLY)-2:0]      corrupted_o,
  output logic [$bits(GEN_POLY)-2:0]            syndrome_o,
  output logic [MSG_W-1:0]                      msg_o,
  output logic                                  err_detected_o,
  output logic                                  err_corrected_o
);

  localparam int PAR_W = $bits(GEN_POLY) - 1;
  localparam int CW_W  = MSG_W + PAR_W;
  localparam int IDX_W = $clog2(CW_W);
  localparam int CNT_W = $clog2(CW_W + 1);

  localparam logic [PAR_W-1:0] POLY_LO  = GEN_POLY[PAR_W-1:0];
  localparam logic [CW_W-1:0]  ONE_CW   = CW_W'(1);
  localparam logic [IDX_W-1:0] LAST_CW  = IDX_W'(CW_W - 1);
  localparam logic [IDX_W-1:0] LAST_MSG = IDX_W'(MSG_W - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENCODE  = 3'd1,
    INJECT  = 3'd2,
    DECODE  = 3'd3,
    CORRECT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [MSG_W-1:0]  msg_cap;
  logic [1:0]        mode;
  logic [CW_W-1:0]   mask_cap;
  logic [CNT_W-1:0]  ecnt;
  logic [CNT_W-1:0]  nset;
  logic [CW_W-1:0]   rmask;
  logic [CW_W-1:0]   sh;
  logic [PAR_W-1:0]  acc;
  logic [15:0]       lfsr;

  // Encode feeds the message bit into the feedback (computes m*x^PAR_W mod g);
  // decode shifts the word bit into the remainder (computes w mod g).
  logic [PAR_W-1:0]  enc_par_next;
  logic [PAR_W-1:0]  dec_rem_next;
  assign enc_par_next = (acc << 1) ^ ((sh[CW_W-1] ^ acc[PAR_W-1]) ? POLY_LO : '0);
  assign dec_rem_next = ((acc << 1) | PAR_W'(sh[CW_W-1])) ^ (acc[PAR_W-1] ? POLY_LO : '0);

  logic [15:0]       lfsr_next;
  logic [IDX_W-1:0]  cand_idx;
  logic [CW_W-1:0]   cand_bit;
  logic              cand_ok;
  logic [CW_W-1:0]   rmask_next;
  logic [CNT_W-1:0]  nset_next;
  logic              inj_done;
  logic [CW_W-1:0]   inj_mask;

  assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign cand_idx   = lfsr[IDX_W-1:0];
  assign cand_bit   = ONE_CW << cand_idx;
  assign cand_ok    = (cand_idx <= LAST_CW) && ((rmask & cand_bit) == '0);
  assign rmask_next = cand_ok ? (rmask | cand_bit) : rmask;
  assign nset_next  = nset + CNT_W'(cand_ok);
  assign inj_done   = (mode != 2'd2) || (nset == ecnt) || (cand_ok && (nset_next == ecnt));
  assign inj_mask   = (mode == 2'd1) ? mask_cap :
                      (mode == 2'd2) ? ((nset == ecnt) ? rmask : rmask_next) : '0;

`ifdef BCH_CORRECT_EN
  logic [PAR_W-1:0]  mr;
  logic [PAR_W-1:0]  mr_next;
  logic [CW_W-1:0]   flipped;
  logic              corrected;
  assign mr_next         = (mr << 1) ^ (mr[PAR_W-1] ? POLY_LO : '0);
  assign flipped         = corrupted_o ^ (ONE_CW << cnt);
  assign err_corrected_o = corrected;
`else
  assign err_corrected_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      msg_cap        <= '0;
      mode           <= '0;
      mask_cap       <= '0;
      ecnt           <= '0;
      nset           <= '0;
      rmask          <= '0;
      sh             <= '0;
      acc            <= '0;
      lfsr           <= 16'hACE1;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      codeword_o     <= '0;
      corrupted_o    <= '0;
      syndrome_o     <= '0;
      msg_o          <= '0;
      err_detected_o <= 1'b0;
`ifdef BCH_CORRECT_EN
      mr             <= '0;
      corrected      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            msg_cap        <= msg_i;
            mode           <= (err_mode_i == 2'd3) ? 2'd0 : err_mode_i;
            mask_cap       <= err_mask_i;
            ecnt           <= (int'(err_cnt_i) > CW_W) ? CNT_W'(CW_W) : CNT_W'(err_cnt_i);
            sh             <= {msg_i, {PAR_W{1'b0}}};
            acc            <= '0;
            cnt            <= '0;
            busy_o         <= 1'b1;
            codeword_o     <= '0;
            corrupted_o    <= '0;
            syndrome_o     <= '0;
            msg_o          <= '0;
            err_detected_o <= 1'b0;
`ifdef BCH_CORRECT_EN
            corrected      <= 1'b0;
`endif
            state          <= ENCODE;
          end
        end
        ENCODE: begin
          acc <= enc_par_next;
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_MSG) begin
            codeword_o <= {msg_cap, enc_par_next};
            rmask      <= '0;
            nset       <= '0;
            state      <= INJECT;
          end
        end
        INJECT: begin
          if (mode == 2'd2) begin
            lfsr  <= lfsr_next;
            rmask <= rmask_next;
            nset  <= nset_next;
          end
          if (inj_done) begin
            corrupted_o <= codeword_o ^ inj_mask;
            sh          <= codeword_o ^ inj_mask;
            acc         <= '0;
            cnt         <= '0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          acc <= dec_rem_next;
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CW) begin
            syndrome_o     <= dec_rem_next;
            err_detected_o <= |dec_rem_next;
`ifdef BCH_CORRECT_EN
            mr             <= PAR_W'(1);
            cnt            <= '0;
            state          <= CORRECT;
`else
            msg_o          <= corrupted_o[CW_W-1:PAR_W];
            done_o         <= 1'b1;
            state          <= DONE;
`endif
          end
        end
`ifdef BCH_CORRECT_EN
        CORRECT: begin
          // mr tracks x^cnt mod g; a match means the lone error sits at bit cnt.
          if (syndrome_o != '0 && mr == syndrome_o) begin
            msg_o     <= flipped[CW_W-1:PAR_W];
            corrected <= 1'b1;
            done_o    <= 1'b1;
            state     <= DONE;
          end else if (syndrome_o == '0 || cnt == LAST_CW) begin
            msg_o  <= corrupted_o[CW_W-1:PAR_W];
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            mr  <= mr_next;
            cnt <= cnt + 1'b1;
          end
        end
`endif
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bch_link_engine.sv
`default_nettype none
// Directed bench for bch_link_engine (default parameters, either build of BCH_CORRECT_EN).
module tb_bch_link_engine;

  localparam int BUDGET = 4000;
`ifdef BCH_CORRECT_EN
  localparam int LAT0 = 24;
  localparam int LAT_SINGLE = 31;
  localparam int LAT_DOUBLE = 36;
  localparam logic EXP_CORR = 1'b1;
  localparam logic [7:0] EXP_MSG_SINGLE = 8'hAA;
`else
  localparam int LAT0 = 23;
  localparam int LAT_SINGLE = 23;
  localparam int LAT_DOUBLE = 23;
  localparam logic EXP_CORR = 1'b0;
  localparam logic [7:0] EXP_MSG_SINGLE = 8'hAE;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  msg_i = '0;
  logic [1:0]  err_mode_i = '0;
  logic [12:0] err_mask_i = '0;
  logic [3:0]  err_cnt_i = '0;
  logic        busy_o, done_o, err_detected_o, err_corrected_o;
  logic [12:0] codeword_o, corrupted_o;
  logic [4:0]  syndrome_o;
  logic [7:0]  msg_o;

  int errors = 0;
  int checks = 0;
  int lat;
  int ndone;
  int mcyc;
  logic busy_t1, busy_after;
  logic [15:0] mlfsr;
  logic [12:0] mmask;

  bch_link_engine dut (
    .clk(clk), .rst(rst), .start_i(start_i), .msg_i(msg_i),
    .err_mode_i(err_mode_i), .err_mask_i(err_mask_i), .err_cnt_i(err_cnt_i),
    .busy_o(busy_o), .done_o(done_o), .codeword_o(codeword_o),
    .corrupted_o(corrupted_o), .syndrome_o(syndrome_o), .msg_o(msg_o),
    .err_detected_o(err_detected_o), .err_corrected_o(err_corrected_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
    check({tag, "_cw"}, 32'(codeword_o), 0);
    check({tag, "_corr_word"}, 32'(corrupted_o), 0);
    check({tag, "_syn"}, 32'(syndrome_o), 0);
    check({tag, "_msg"}, 32'(msg_o), 0);
    check({tag, "_det"}, 32'(err_detected_o), 0);
    check({tag, "_fix"}, 32'(err_corrected_o), 0);
  endtask

  // Start one operation; lat = edges from the sampling edge to the done_o edge.
  task automatic do_op(input logic [7:0] m, input logic [1:0] mode, input logic [12:0] mask,
                       input logic [3:0] cnt, output int l);
    @(negedge clk);
    msg_i = m; err_mode_i = mode; err_mask_i = mask; err_cnt_i = cnt; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    busy_t1 = busy_o;
    l = 1;
    while (!done_o && l < BUDGET) begin
      @(posedge clk); #1;
      l++;
    end
    @(posedge clk); #1;
    busy_after = busy_o;
  endtask

  // Reference random-mask generator: index from the current LFSR value, then advance.
  task automatic gen_mask(input int cnt, output logic [12:0] m, output int cyc);
    int c;
    int n;
    logic [3:0] idx;
    c = (cnt > 13) ? 13 : cnt;
    n = 0;
    m = '0;
    cyc = 0;
    while (1) begin
      cyc++;
      idx = mlfsr[3:0];
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
      if (n == c) break;
      if (idx < 13 && !m[idx]) begin
        m[idx] = 1'b1;
        n++;
        if (n == c) break;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean encode
    do_op(8'hAA, 2'd0, 13'h0, 4'd0, lat);
    check("clean_lat", 32'(lat), 32'(LAT0));
    check("clean_busy_t1", 32'(busy_t1), 1);
    check("clean_busy_fall", 32'(busy_after), 0);
    check("clean_cw", 32'(codeword_o), 32'h1558);
    check("clean_corrupt", 32'(corrupted_o), 32'h1558);
    check("clean_syn", 32'(syndrome_o), 0);
    check("clean_det", 32'(err_detected_o), 0);
    check("clean_fix", 32'(err_corrected_o), 0);
    check("clean_msg", 32'(msg_o), 32'hAA);

    // Single error at bit 7
    do_op(8'hAA, 2'd1, 13'h0080, 4'd0, lat);
    check("single_lat", 32'(lat), 32'(LAT_SINGLE));
    check("single_corrupt", 32'(corrupted_o), 32'h15D8);
    check("single_syn", 32'(syndrome_o), 32'h14);
    check("single_det", 32'(err_detected_o), 1);
    check("single_fix", 32'(err_corrected_o), 32'(EXP_CORR));
    check("single_msg", 32'(msg_o), 32'(EXP_MSG_SINGLE));

    // Double error in parity bits 0 and 1
    do_op(8'hAA, 2'd1, 13'h0003, 4'd0, lat);
    check("double_lat", 32'(lat), 32'(LAT_DOUBLE));
    check("double_corrupt", 32'(corrupted_o), 32'h155B);
    check("double_syn", 32'(syndrome_o), 32'h03);
    check("double_det", 32'(err_detected_o), 1);
    check("double_fix", 32'(err_corrected_o), 0);
    check("double_msg", 32'(msg_o), 32'hAA);

    // Mode 3 behaves as no injection; different message
    do_op(8'h3C, 2'd3, 13'h1FFF, 4'd5, lat);
    check("mode3_lat", 32'(lat), 32'(LAT0));
    check("mode3_corrupt", 32'(corrupted_o), 32'(codeword_o));
    check("mode3_cw_msg", 32'(codeword_o[12:5]), 32'h3C);
    check("mode3_syn", 32'(syndrome_o), 0);

    // Start while busy is ignored
    @(negedge clk);
    msg_i = 8'hAA; err_mode_i = 2'd0; err_mask_i = '0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    ndone = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    msg_i = 8'h55; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_o) ndone++;
      @(posedge clk); #1;
    end
    check("busy_start_ndone", 32'(ndone), 1);
    check("busy_start_cw", 32'(codeword_o), 32'h1558);
    check("busy_start_msg", 32'(msg_o), 32'hAA);

    // Reset during DECODE
    @(negedge clk);
    msg_i = 8'hAA; err_mode_i = 2'd1; err_mask_i = 13'h0080; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy_o), 1);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    do_op(8'hAA, 2'd0, 13'h0, 4'd0, lat);
    check("after_reset_cw", 32'(codeword_o), 32'h1558);
    check("after_reset_lat", 32'(lat), 32'(LAT0));

    // Random injection from the reset seed
    mlfsr = 16'hACE1;
    gen_mask(3, mmask, mcyc);
    do_op(8'hAA, 2'd2, 13'h0, 4'd3, lat);
    check("rand3_pop", 32'($countones(corrupted_o ^ codeword_o)), 3);
    check("rand3_mask", 32'(corrupted_o ^ codeword_o), 32'(mmask));
    check("rand3_lat", 32'(lat), 32'(LAT0 + mcyc - 1));

    gen_mask(15, mmask, mcyc);
    do_op(8'hAA, 2'd2, 13'h0, 4'd15, lat);
    check("rand15_pop", 32'($countones(corrupted_o ^ codeword_o)), 13);
    check("rand15_mask", 32'(corrupted_o ^ codeword_o), 32'(mmask));
    check("rand15_lat", 32'(lat), 32'(LAT0 + mcyc - 1));

    // Count 0 in random mode: single-cycle inject, no flips
    gen_mask(0, mmask, mcyc);
    do_op(8'h5A, 2'd2, 13'h0, 4'd0, lat);
    check("rand0_mask", 32'(corrupted_o ^ codeword_o), 0);
    check("rand0_lat", 32'(lat), 32'(LAT0));

    // After reset the LFSR restarts: same first mask again
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mlfsr = 16'hACE1;
    gen_mask(3, mmask, mcyc);
    do_op(8'hAA, 2'd2, 13'h0, 4'd3, lat);
    check("rand3_repeat_mask", 32'(corrupted_o ^ codeword_o), 32'(mmask));
    check("rand3_repeat_pop", 32'($countones(corrupted_o ^ codeword_o)), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bch_link_engine.md
# bch_link_engine

Parametrised BCH link engine: a bit-serial, sequential successor to the single-shot encode/noise/decode controller. It carries one message per operation through four stages: systematic cyclic encoding with a configurable generator polynomial, controlled error injection (fixed mask or LFSR-random positions), syndrome decoding, and optional single-error correction. It sits between the AXI-Lite register file (which drives its inputs) and the status/LED logic.

## Interface
- `MSG_W`, default 8: message width k.
- `GEN_POLY`, default 6'b100101: generator g(x), MSB = x^PAR_W; default is x^5+x^2+1.
- Localparams: `PAR_W = $bits(GEN_POLY)-1`; `CW_W = MSG_W+PAR_W` (13 by default); `IDX_W = $clog2(CW_W)`.
- Reset is `rst`, asynchronous, active-high. The clock is `clk`.
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `start_i` in 1: operation request; sampled only in IDLE.
- `msg_i` in MSG_W: message; captured at start.
- `err_mode_i` in 2: 0 = none, 1 = fixed mask, 2 = random, 3 = treated as 0; captured at start.
- `err_mask_i` in CW_W: error mask for mode 1; captured at start.
- `err_cnt_i` in 4: number of random errors for mode 2; captured at start and clamped to CW_W.
- `busy_o` out 1: high whenever the FSM is not in IDLE.
- `done_o` out 1: one-cycle pulse in the DONE state.
- `codeword_o` out CW_W: clean codeword, {msg, parity}.
- `corrupted_o` out CW_W: codeword after injection.
- `syndrome_o` out PAR_W: remainder of corrupted word mod g.
- `msg_o` out MSG_W: decoded message.
- `err_detected_o` out 1: syndrome is nonzero.
- `err_corrected_o` out 1: a single-bit correction was applied.
- Reset value of every output is 0.

## Operation
- FSM: IDLE → ENCODE → INJECT → DECODE → CORRECT → DONE → IDLE.
- **IDLE**: when `start_i`=1, capture all inputs, clear all result outputs, and enter ENCODE. `start_i` is ignored in every other state.
- **ENCODE** (MSG_W cycles): LFSR division of msg·x^PAR_W by g, message MSB first.
  - Arithmetic is GF(2) only: XOR, no integer multiply.
  - Result: `codeword_o = {msg, parity}`; bit j of the codeword corresponds to x^j.
- **INJECT**:
  - Modes 0 and 1 take 1 cycle: `corrupted_o = codeword ^ mask` (mask is 0 in mode 0).
  - Mode 2 builds the mask one candidate per cycle from a 16-bit Fibonacci LFSR:
    - Feedback = l[15]^l[13]^l[12]^l[10]; shift left. Seed 16'hACE1 applies at reset only; the LFSR is not reseeded between operations.
    - The LFSR advances once per mode-2 INJECT cycle. Candidate index = l[IDX_W-1:0].
    - The candidate is rejected if index ≥ CW_W or the bit is already set; otherwise the bit is set.
    - Leave when popcount equals the clamped count. If the count is 0, this takes 1 cycle with mask 0.
    - The result is always exactly `min(err_cnt_i, CW_W)` distinct flipped bits.
- **DECODE** (CW_W cycles): serial remainder of the corrupted word mod g, MSB first. Produces `syndrome_o`, and sets `err_detected_o = |syndrome`.
- **CORRECT**: Meggitt search.
  - Start with r = 1, i = 0.
  - Each cycle: if r == syndrome, flip bit i of the working word, set `err_corrected_o`, and go to DONE. Otherwise r = r·x mod g and i++.
  - A zero syndrome exits after 1 cycle with no flip.
  - If i reaches CW_W with no match, exit with `err_corrected_o` = 0 (uncorrectable).
- `msg_o` = working word [CW_W-1:PAR_W] (corrected if a flip was applied).
- Results hold stable after DONE until the next accepted start.

## Timing
- `start_i` is sampled at cycle T; `busy_o` is high from T+1.
- Mode 0/1 with zero syndrome: `done_o` pulses at T+MSG_W+CW_W+3 (T+24 by default). `busy_o` falls in the cycle after `done_o`.
- Error at bit j adds j cycles to CORRECT. An uncorrectable word adds CW_W-1 cycles.
- Mode 2 adds (INJECT cycles − 1).
- Async `rst` mid-operation: FSM goes to IDLE, all outputs go to 0, and the LFSR returns to 16'hACE1.
- Earliest next accepted start is the cycle after `done_o`.

## Configuration
- **`BCH_CORRECT_EN` defined**: the CORRECT state is built as described above.
- **Not defined**: CORRECT is not synthesised.
  - DECODE goes directly to DONE, so `done_o` comes one cycle earlier (T+23 by default).
  - `err_corrected_o` is tied to 0.
  - `msg_o` = `corrupted_o[CW_W-1:PAR_W]`.
  - `err_detected_o` behaves the same as with the macro defined.

## Test plan
- **Clean encode**: `msg_i`=8'hAA, mode 0 → `codeword_o`=13'h1558, `syndrome_o`=0, `err_detected_o`=0, `msg_o`=8'hAA. With the macro defined, `done_o` is exactly at T+24.
- **Single error in a message bit**: mask 13'h0080 → `corrupted_o`=13'h15D8, `syndrome_o`=5'b10100, `err_detected_o`=1, `err_corrected_o`=1, `msg_o`=8'hAA, `done_o` at T+31.
- **Double error**: mask 13'h0003 → `syndrome_o`=5'b00011, `err_detected_o`=1, `err_corrected_o`=0, `msg_o`=8'hAA. Without the macro, `err_corrected_o` is also 0.
- **Random injection**: `err_cnt_i`=3 then 15 (from the reset seed) → popcount(`corrupted_o`^`codeword_o`) is 3, then 13. The mask is reproducible after a reset.
- **Reset mid-operation**: assert `rst` in DECODE → all outputs 0 at once. A following start with 8'hAA again yields 13'h1558.
- **Start while busy**: pulse `start_i` with 8'h55 during ENCODE of 8'hAA → ignored. Results are for 8'hAA and only one `done_o` is seen.
